// File: rtl/conv3d_pkg.sv
// Shared types and helpers for the 3D transposed-convolution gather engine.
//   state_e   : engine FSM states
//   out_dim   : transposed-convolution output extent for one axis
//   cnt_w     : counter/address width that stays >= 1 for degenerate extents
//   sat_shift : arithmetic shift right by frac, then clamp to a signed data_w range
package conv3d_pkg;

    typedef enum logic [2:0] {StIdle, StTap, StDrain, StEmit, StDone} state_e;

    function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned stride,
                                            input int unsigned pad, input int unsigned k,
                                            input int unsigned opad);
        return (in_dim - 1) * stride - 2 * pad + k + opad;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [63:0] sat_shift(input logic signed [63:0] acc,
                                              input int unsigned frac,
                                              input int unsigned data_w);
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = acc >>> frac;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (sh > hi) begin
            return hi;
        end else if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

endpackage

// File: rtl/conv3d_tap_gen.sv
// Tap and voxel sequencer for the gather-form transposed convolution.
// Tap counters (ic, kd, kh, kw; kw fastest) step on tap_adv; voxel counters
// (oc, od, oh, ow; ow fastest) step on vox_adv. For the current (voxel, tap)
// pair it resolves which input voxel, if any, contributes.
//   clk, rst_n       : clock, async active-low reset
//   tap_adv, vox_adv : advance tap / voxel counters
//   in_addr, w_addr  : read addresses, 0 when the tap is invalid
//   tap_valid        : current tap maps onto a real input voxel
//   last_tap         : current tap is the last one of the voxel
//   last_vox         : current voxel is the last one of the tensor
//   vox_idx          : linear raster index of the current voxel
module conv3d_tap_gen
    import conv3d_pkg::*;
#(
    parameter int unsigned CIN   = 2,
    parameter int unsigned COUT  = 2,
    parameter int unsigned ID    = 4,
    parameter int unsigned IH    = 4,
    parameter int unsigned IW    = 4,
    parameter int unsigned KD    = 3,
    parameter int unsigned KH    = 3,
    parameter int unsigned KW    = 3,
    parameter int unsigned SD    = 2,
    parameter int unsigned SH    = 2,
    parameter int unsigned SW    = 2,
    parameter int unsigned PD    = 1,
    parameter int unsigned PH    = 1,
    parameter int unsigned PW    = 1,
    parameter int unsigned OPD   = 1,
    parameter int unsigned OPH   = 1,
    parameter int unsigned OPW   = 1,
    parameter int unsigned IN_AW = 7,
    parameter int unsigned W_AW  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tap_adv,
    input  logic             vox_adv,
    output logic [IN_AW-1:0] in_addr,
    output logic [W_AW-1:0]  w_addr,
    output logic             tap_valid,
    output logic             last_tap,
    output logic             last_vox,
    output logic [31:0]      vox_idx
);

    localparam int unsigned OD = out_dim(ID, SD, PD, KD, OPD);
    localparam int unsigned OH = out_dim(IH, SH, PH, KH, OPH);
    localparam int unsigned OW = out_dim(IW, SW, PW, KW, OPW);

    localparam int unsigned IC_W = cnt_w(CIN);
    localparam int unsigned KD_W = cnt_w(KD);
    localparam int unsigned KH_W = cnt_w(KH);
    localparam int unsigned KW_W = cnt_w(KW);
    localparam int unsigned OC_W = cnt_w(COUT);
    localparam int unsigned OD_W = cnt_w(OD);
    localparam int unsigned OH_W = cnt_w(OH);
    localparam int unsigned OW_W = cnt_w(OW);

    logic [IC_W-1:0] ic_q;
    logic [KD_W-1:0] kd_q;
    logic [KH_W-1:0] kh_q;
    logic [KW_W-1:0] kw_q;
    logic [OC_W-1:0] oc_q;
    logic [OD_W-1:0] od_q;
    logic [OH_W-1:0] oh_q;
    logic [OW_W-1:0] ow_q;
    logic [31:0]     vox_idx_q;

    logic kw_wrap, kh_wrap, kd_wrap, ic_wrap;
    logic ow_wrap, oh_wrap, od_wrap, oc_wrap;

    // Each wrap flag means "this counter and all faster ones are at their last value".
    assign kw_wrap = (kw_q == KW_W'(KW - 1));
    assign kh_wrap = kw_wrap && (kh_q == KH_W'(KH - 1));
    assign kd_wrap = kh_wrap && (kd_q == KD_W'(KD - 1));
    assign ic_wrap = kd_wrap && (ic_q == IC_W'(CIN - 1));
    assign ow_wrap = (ow_q == OW_W'(OW - 1));
    assign oh_wrap = ow_wrap && (oh_q == OH_W'(OH - 1));
    assign od_wrap = oh_wrap && (od_q == OD_W'(OD - 1));
    assign oc_wrap = od_wrap && (oc_q == OC_W'(COUT - 1));

    assign last_tap = ic_wrap;
    assign last_vox = oc_wrap;
    assign vox_idx  = vox_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic_q      <= '0;
            kd_q      <= '0;
            kh_q      <= '0;
            kw_q      <= '0;
            oc_q      <= '0;
            od_q      <= '0;
            oh_q      <= '0;
            ow_q      <= '0;
            vox_idx_q <= '0;
        end else begin
            if (tap_adv) begin
                kw_q <= kw_wrap ? '0 : kw_q + KW_W'(1);
                if (kw_wrap) kh_q <= kh_wrap ? '0 : kh_q + KH_W'(1);
                if (kh_wrap) kd_q <= kd_wrap ? '0 : kd_q + KD_W'(1);
                if (kd_wrap) ic_q <= ic_wrap ? '0 : ic_q + IC_W'(1);
            end
            if (vox_adv) begin
                ow_q <= ow_wrap ? '0 : ow_q + OW_W'(1);
                if (ow_wrap) oh_q <= oh_wrap ? '0 : oh_q + OH_W'(1);
                if (oh_wrap) od_q <= od_wrap ? '0 : od_q + OD_W'(1);
                if (od_wrap) oc_q <= oc_wrap ? '0 : oc_q + OC_W'(1);
                vox_idx_q <= oc_wrap ? '0 : vox_idx_q + 32'd1;
            end
        end
    end

    // Offset of the output position from the kernel tap, in upsampled input space.
    // A tap contributes only when the offset lands exactly on a stride point inside the input.
    int  td, th, tw, ia, wa;
    logic vd, vh, vw;

    always_comb begin
        td = int'(od_q) + int'(PD) - int'(kd_q);
        th = int'(oh_q) + int'(PH) - int'(kh_q);
        tw = int'(ow_q) + int'(PW) - int'(kw_q);
        vd = (td >= 0) && (td % int'(SD) == 0) && (td / int'(SD) < int'(ID));
        vh = (th >= 0) && (th % int'(SH) == 0) && (th / int'(SH) < int'(IH));
        vw = (tw >= 0) && (tw % int'(SW) == 0) && (tw / int'(SW) < int'(IW));
        tap_valid = vd && vh && vw;
        ia = ((int'(ic_q) * int'(ID) + td / int'(SD)) * int'(IH) + th / int'(SH)) * int'(IW)
             + tw / int'(SW);
        wa = (((int'(ic_q) * int'(COUT) + int'(oc_q)) * int'(KD) + int'(kd_q)) * int'(KH)
              + int'(kh_q)) * int'(KW) + int'(kw_q);
        in_addr = tap_valid ? IN_AW'(ia) : '0;
        w_addr  = tap_valid ? W_AW'(wa) : '0;
    end

endmodule

// File: rtl/conv_transposed_3d_gather_engine.sv
// Fixed-point 3D transposed convolution (gather form, no bias, groups = 1).
// Walks every output voxel in raster order (oc, od, oh, ow), gathers its taps
// from external 1-cycle-latency memories and emits one saturated sample per
// valid/ready handshake.
//   clk, rst_n          : clock, async active-low reset
//   start, busy, done   : pass control / status (done is a one-cycle pulse)
//   in_addr, in_rdata   : input-tensor memory port
//   w_addr, w_rdata     : weight memory port
//   out_valid/ready     : output handshake
//   out_data, out_idx   : saturated sample and its linear output index
module conv_transposed_3d_gather_engine
    import conv3d_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned CIN    = 2,
    parameter int unsigned COUT   = 2,
    parameter int unsigned ID     = 4,
    parameter int unsigned IH     = 4,
    parameter int unsigned IW     = 4,
    parameter int unsigned KD     = 3,
    parameter int unsigned KH     = 3,
    parameter int unsigned KW     = 3,
    parameter int unsigned SD     = 2,
    parameter int unsigned SH     = 2,
    parameter int unsigned SW     = 2,
    parameter int unsigned PD     = 1,
    parameter int unsigned PH     = 1,
    parameter int unsigned PW     = 1,
    parameter int unsigned OPD    = 1,
    parameter int unsigned OPH    = 1,
    parameter int unsigned OPW    = 1,
    localparam int unsigned IN_AW = cnt_w(CIN * ID * IH * IW),
    localparam int unsigned W_AW  = cnt_w(CIN * COUT * KD * KH * KW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    input  logic [DATA_W-1:0] in_rdata,
    output logic [W_AW-1:0]   w_addr,
    input  logic [DATA_W-1:0] w_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_idx
);

    state_e state_q;

    logic             tap_adv;
    logic             hs;
    logic [IN_AW-1:0] tg_in_addr;
    logic [W_AW-1:0]  tg_w_addr;
    logic             tap_valid;
    logic             last_tap;
    logic             last_vox;
    logic [31:0]      vox_idx;

    logic                     tap_ok_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    assign tap_adv = (state_q == StTap);
    assign hs      = out_valid && out_ready;

    conv3d_tap_gen #(
        .CIN   (CIN),
        .COUT  (COUT),
        .ID    (ID),
        .IH    (IH),
        .IW    (IW),
        .KD    (KD),
        .KH    (KH),
        .KW    (KW),
        .SD    (SD),
        .SH    (SH),
        .SW    (SW),
        .PD    (PD),
        .PH    (PH),
        .PW    (PW),
        .OPD   (OPD),
        .OPH   (OPH),
        .OPW   (OPW),
        .IN_AW (IN_AW),
        .W_AW  (W_AW)
    ) u_tap_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .tap_adv   (tap_adv),
        .vox_adv   (hs),
        .in_addr   (tg_in_addr),
        .w_addr    (tg_w_addr),
        .tap_valid (tap_valid),
        .last_tap  (last_tap),
        .last_vox  (last_vox),
        .vox_idx   (vox_idx)
    );

    // Addresses are only meaningful while gathering; park them at 0 otherwise.
    assign in_addr = tap_adv ? tg_in_addr : '0;
    assign w_addr  = tap_adv ? tg_w_addr : '0;

    // Read data arrives one cycle after the address, so the MAC uses the piped tap flag.
    always_comb begin
        prod     = $signed(in_rdata) * $signed(w_rdata);
        prod_ext = tap_ok_q ? ACC_W'(prod) : '0;
        acc_d    = acc_q + prod_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            acc_q     <= '0;
            tap_ok_q  <= 1'b0;
        end else begin
            tap_ok_q <= tap_adv && tap_valid;
            acc_q    <= acc_d;
            done     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StTap;
                        busy    <= 1'b1;
                        acc_q   <= '0;
                    end
                end
                StTap: begin
                    if (last_tap) state_q <= StDrain;
                end
                StDrain: begin
                    // acc_d already includes the final product landing this cycle.
                    state_q   <= StEmit;
                    out_valid <= 1'b1;
                    out_data  <= DATA_W'(sat_shift(64'(acc_d), FRAC, DATA_W));
                    out_idx   <= vox_idx;
                end
                StEmit: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_vox) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StTap;
                            acc_q   <= '0;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_transposed_3d_gather_engine.sv
// Randomised self-checking bench. Three engine instances cover a 1x1x1 identity
// kernel, a stride-2 2x2x2 kernel and the default configuration. Expected samples
// come from a scatter-form reference: every (input voxel, kernel tap) pair whose
// upsampled position id*S - P + k equals the output position contributes.
module tb_conv_transposed_3d_gather_engine;

    typedef struct {
        int cin;
        int cout;
        int i;
        int k;
        int s;
        int p;
        int op;
        int o;
    } cfg_t;

    logic clk;
    logic rst_n;
    logic start;
    logic out_ready;
    int   sel;

    cfg_t        cfg [3];
    logic [15:0] in_mem [3][256];
    logic [15:0] w_mem [3][256];
    logic [15:0] rd_in [3];
    logic [15:0] rd_w [3];

    int n_checks;
    int n_fail;

    // Instance A: 1x1x1 kernel, stride 1, no padding.
    logic        busy_a, done_a, valid_a;
    logic [5:0]  in_addr_a;
    logic [0:0]  w_addr_a;
    logic [15:0] data_a;
    logic [31:0] idx_a;
    // Instance B: 2x2x2 kernel, stride 2.
    logic        busy_b, done_b, valid_b;
    logic [2:0]  in_addr_b;
    logic [2:0]  w_addr_b;
    logic [15:0] data_b;
    logic [31:0] idx_b;
    // Instance C: default parameters.
    logic        busy_c, done_c, valid_c;
    logic [6:0]  in_addr_c;
    logic [6:0]  w_addr_c;
    logic [15:0] data_c;
    logic [31:0] idx_c;

    conv_transposed_3d_gather_engine #(
        .CIN(1), .COUT(1), .ID(4), .IH(4), .IW(4), .KD(1), .KH(1), .KW(1),
        .SD(1), .SH(1), .SW(1), .PD(0), .PH(0), .PW(0), .OPD(0), .OPH(0), .OPW(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .busy(busy_a), .done(done_a),
        .in_addr(in_addr_a), .in_rdata(rd_in[0]), .w_addr(w_addr_a), .w_rdata(rd_w[0]),
        .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a), .out_idx(idx_a)
    );

    conv_transposed_3d_gather_engine #(
        .CIN(1), .COUT(1), .ID(2), .IH(2), .IW(2), .KD(2), .KH(2), .KW(2),
        .SD(2), .SH(2), .SW(2), .PD(0), .PH(0), .PW(0), .OPD(0), .OPH(0), .OPW(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .busy(busy_b), .done(done_b),
        .in_addr(in_addr_b), .in_rdata(rd_in[1]), .w_addr(w_addr_b), .w_rdata(rd_w[1]),
        .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b), .out_idx(idx_b)
    );

    conv_transposed_3d_gather_engine u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .busy(busy_c), .done(done_c),
        .in_addr(in_addr_c), .in_rdata(rd_in[2]), .w_addr(w_addr_c), .w_rdata(rd_w[2]),
        .out_valid(valid_c), .out_ready(out_ready), .out_data(data_c), .out_idx(idx_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data one cycle after address.
    always @(posedge clk) begin
        rd_in[0] <= in_mem[0][in_addr_a];
        rd_w[0]  <= w_mem[0][w_addr_a];
        rd_in[1] <= in_mem[1][in_addr_b];
        rd_w[1]  <= w_mem[1][w_addr_b];
        rd_in[2] <= in_mem[2][in_addr_c];
        rd_w[2]  <= w_mem[2][w_addr_c];
    end

    logic        cur_valid, cur_busy, cur_done;
    logic [15:0] cur_data;
    logic [31:0] cur_idx;
    int          cur_in_addr, cur_w_addr;

    always_comb begin
        cur_valid = valid_a; cur_busy = busy_a; cur_done = done_a; cur_data = data_a;
        cur_idx = idx_a; cur_in_addr = int'(in_addr_a); cur_w_addr = int'(w_addr_a);
        if (sel == 1) begin
            cur_valid = valid_b; cur_busy = busy_b; cur_done = done_b; cur_data = data_b;
            cur_idx = idx_b; cur_in_addr = int'(in_addr_b); cur_w_addr = int'(w_addr_b);
        end else if (sel == 2) begin
            cur_valid = valid_c; cur_busy = busy_c; cur_done = done_c; cur_data = data_c;
            cur_idx = idx_c; cur_in_addr = int'(in_addr_c); cur_w_addr = int'(w_addr_c);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic cfg_t mk(input int cin, input int cout, input int i, input int k,
                                input int s, input int p, input int op);
        cfg_t c;
        c.cin = cin; c.cout = cout; c.i = i; c.k = k; c.s = s; c.p = p; c.op = op;
        c.o = (i - 1) * s - 2 * p + k + op;
        return c;
    endfunction

    // Scatter-form reference for output voxel n of configuration s.
    function automatic logic [15:0] model(input int s, input int n);
        cfg_t   c;
        int     ow, oh, od, oc, ia, wa;
        longint acc, sh;
        c  = cfg[s];
        ow = n % c.o;
        oh = (n / c.o) % c.o;
        od = (n / (c.o * c.o)) % c.o;
        oc = n / (c.o * c.o * c.o);
        acc = 0;
        for (int ic = 0; ic < c.cin; ic++)
            for (int zd = 0; zd < c.i; zd++)
                for (int kd = 0; kd < c.k; kd++) begin
                    if (zd * c.s - c.p + kd != od) continue;
                    for (int zh = 0; zh < c.i; zh++)
                        for (int kh = 0; kh < c.k; kh++) begin
                            if (zh * c.s - c.p + kh != oh) continue;
                            for (int zw = 0; zw < c.i; zw++)
                                for (int kw = 0; kw < c.k; kw++) begin
                                    if (zw * c.s - c.p + kw != ow) continue;
                                    ia = ((ic * c.i + zd) * c.i + zh) * c.i + zw;
                                    wa = (((ic * c.cout + oc) * c.k + kd) * c.k + kh) * c.k + kw;
                                    acc += longint'($signed(in_mem[s][ia]))
                                         * longint'($signed(w_mem[s][wa]));
                                end
                        end
                end
        sh = acc >>> 8;
        if (sh > 32767) sh = 32767;
        if (sh < -32768) sh = -32768;
        return sh[15:0];
    endfunction

    // rdy_mode 0: always ready, 1: random ready, 2: ten-cycle stall on voxel 3.
    task automatic run_pass(input int s, input int max_vox, input int rdy_mode,
                            output logic [15:0] first_data);
        int          n, cyc, total, ntaps, budget, last_hs, stall, done_cnt;
        bit          held;
        logic [15:0] hd;
        logic [31:0] hi;
        int          ha, hw;
        total   = cfg[s].cout * cfg[s].o * cfg[s].o * cfg[s].o;
        ntaps   = cfg[s].cin * cfg[s].k * cfg[s].k * cfg[s].k;
        budget  = max_vox * (ntaps + 2) * 3 + 200;
        n = 0; cyc = 0; last_hs = 0; stall = 0; done_cnt = 0; held = 0;
        hd = '0; hi = '0; ha = 0; hw = 0; first_data = '0;
        sel = s;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n < max_vox && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 20);  // must be ignored while busy
            if (cyc == 2) check("busy_in_pass", cur_busy, 1);
            if (cur_done) done_cnt++;
            if (held) begin
                check("hold_valid", cur_valid, 1);
                check("hold_data", cur_data, hd);
                check("hold_idx", cur_idx, hi);
                check("hold_in_addr", cur_in_addr, ha);
                check("hold_w_addr", cur_w_addr, hw);
            end
            held = 0;
            if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 2) begin
                out_ready = 1'b1;
                if (cur_valid && n == 3 && stall < 10) begin
                    out_ready = 1'b0;
                    stall++;
                end
            end else out_ready = 1'b1;
            if (cur_valid && out_ready) begin
                check("out_idx", cur_idx, n);
                check("out_data", cur_data, model(s, n));
                if (n == 0) first_data = cur_data;
                if (rdy_mode == 0 && n > 0) check("voxel_latency", cyc - last_hs, ntaps + 2);
                last_hs = cyc;
                n++;
            end else if (cur_valid) begin
                held = 1;
                hd = cur_data; hi = cur_idx; ha = cur_in_addr; hw = cur_w_addr;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("vox_count", n, max_vox);
        if (rdy_mode == 2) check("stall_cycles", stall, 10);
        if (max_vox == total) begin
            repeat (4) begin
                @(negedge clk);
                if (cur_done) begin
                    done_cnt++;
                    check("busy_at_done", cur_busy, 0);
                end
            end
            check("done_pulses", done_cnt, 1);
            check("idle_after", cur_busy, 0);
        end else begin
            check("early_done", done_cnt, 0);
        end
    endtask

    logic [15:0] fd;
    int          dn;

    initial begin
        cfg[0] = mk(1, 1, 4, 1, 1, 0, 0);
        cfg[1] = mk(1, 1, 2, 2, 2, 0, 0);
        cfg[2] = mk(2, 2, 4, 3, 2, 1, 1);
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; sel = 0;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 256; i++) begin
                in_mem[s][i] = '0;
                w_mem[s][i] = '0;
            end

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_idx", idx_a, 0);
        check("rst_in_addr", in_addr_a, 0);
        check("rst_w_addr", w_addr_a, 0);
        check("c_dim", cfg[2].o, 8);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity kernel on a ramp: output equals input.
        for (int i = 0; i < 64; i++) in_mem[0][i] = 16'(i);
        w_mem[0][0] = 16'h0100;
        run_pass(0, 64, 0, fd);
        check("a_ramp_first", fd, 0);

        // Saturation in both directions.
        for (int i = 0; i < 64; i++) in_mem[0][i] = 16'h7fff;
        w_mem[0][0] = 16'h7fff;
        run_pass(0, 64, 1, fd);
        check("a_sat_pos", fd, 16'h7fff);
        for (int i = 0; i < 64; i++) in_mem[0][i] = 16'h8000;
        run_pass(0, 64, 1, fd);
        check("a_sat_neg", fd, 16'h8000);

        // Random data with a long stall, then random backpressure.
        for (int i = 0; i < 64; i++) in_mem[0][i] = 16'($urandom);
        w_mem[0][0] = 16'($urandom_range(0, 511)) - 16'd256;
        run_pass(0, 64, 2, fd);
        run_pass(0, 64, 1, fd);

        // Stride-2 2x2x2 kernel, all ones: exactly one tap per output.
        for (int i = 0; i < 8; i++) begin
            in_mem[1][i] = 16'h0100;
            w_mem[1][i] = 16'h0100;
        end
        run_pass(1, 64, 0, fd);
        check("b_ones_first", fd, 16'h0100);
        for (int i = 0; i < 8; i++) begin
            in_mem[1][i] = 16'($urandom);
            w_mem[1][i] = 16'($urandom_range(0, 1023)) - 16'd512;
        end
        run_pass(1, 64, 1, fd);

        // Default configuration, all ones: corner voxel gathers one tap per input channel.
        for (int i = 0; i < 128; i++) in_mem[2][i] = 16'h0100;
        for (int i = 0; i < 108; i++) w_mem[2][i] = 16'h0100;
        run_pass(2, 5, 0, fd);
        check("c_corner", fd, 16'h0200);

        // Reset in the middle of gathering voxel 5.
        @(negedge clk);
        check("c_busy_pre_rst", busy_c, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_c, 0);
        check("mid_rst_done", done_c, 0);
        check("mid_rst_valid", valid_c, 0);
        check("mid_rst_data", data_c, 0);
        check("mid_rst_idx", idx_c, 0);
        check("mid_rst_in_addr", in_addr_c, 0);
        check("mid_rst_w_addr", w_addr_c, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_c) dn++;
        end
        check("rst_no_done", dn, 0);
        check("rst_idle", busy_c, 0);

        // Full default pass on random data.
        for (int i = 0; i < 128; i++) in_mem[2][i] = 16'($urandom_range(0, 4095)) - 16'd2048;
        for (int i = 0; i < 108; i++) w_mem[2][i] = 16'($urandom_range(0, 4095)) - 16'd2048;
        run_pass(2, 1024, 0, fd);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
